onehot_encoder_pipe: RTL
========================

# onehot_encoder_pipe

Parametrised, handshaked one-hot-to-binary encoder with a 2-entry output buffer. It converts a `WIDTH_P`-bit one-hot (or multi-hot) vector into a binary index, with selectable strict or priority decoding. It also flags and counts malformed inputs. It sits between request-select logic and index-consuming datapaths, and stalls cleanly under downstream backpressure.

## Interface
- `WIDTH_P`, 10, input vector width; must be ≥ 2.
- `IDX_W_P`, `$clog2(WIDTH_P+1)`, output index width; 4 at the default.
- `ERR_CNT_W_P`, 8, error counter width.

Ports (clock and reset first):
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `valid_i`  in  1  input vector valid.
- `ready_o`  out  1  block can accept; high when the buffer holds fewer than 2 entries.
- `one_hot_i`  in  `WIDTH_P`  input vector.
- `mode_i`  in  2  decode mode, sampled with each accepted vector: 00 strict, 01 priority-LSB, 10 priority-MSB, 11 treated as strict.
- `valid_o`  out  1  output entry valid; high when the buffer is non-empty.
- `ready_i`  in  1  downstream accepts the output.
- `binary_o`  out  `IDX_W_P`  encoded index of the head entry.
- `zero_o`  out  1  head entry's input was all-zero.
- `err_o`  out  1  head entry was multi-hot in strict mode.
- `clear_err_i`  in  1  synchronous clear of `err_cnt_o`.
- `err_cnt_o`  out  `ERR_CNT_W_P`  saturating count of accepted strict-mode multi-hot vectors.

## Operation
- Encoding: an all-zero vector gives index 0 with `zero_o`=1. A single set bit k gives index k+1 (bit 0 → 1, bit 9 → 10).
- Strict mode:
  - popcount ≤ 1: encode as above.
  - popcount ≥ 2: index 0, `err_o`=1, `zero_o`=0.
- Priority-LSB mode: index = (position of the lowest set bit)+1. `err_o` is never set.
- Priority-MSB mode: index = (position of the highest set bit)+1. `err_o` is never set.
- Transfer in: occurs when `valid_i && ready_o`. The encoded result, `zero` and `err` are computed combinationally and written into the buffer in the same edge.
- Transfer out: occurs when `valid_o && ready_i`; pops the head entry.
- Buffer: 2-entry FIFO with 2-bit count.
  - `ready_o` = (count != 2), derived from registers only; no combinational path from `ready_i`.
  - Push and pop in the same cycle with count 1: count stays 1, and the new entry becomes the head.
  - At count 2, a push is refused even if a pop occurs in the same cycle.
- Error counter:
  - Increments on each accepted strict/11-mode vector with popcount ≥ 2.
  - Saturates at all-ones.
  - If `clear_err_i` and an increment occur in the same cycle, clear wins and the result is 0.
  - Counting is independent of output consumption.
- When `valid_o`=0, `binary_o`, `zero_o` and `err_o` are 0.

## Timing
- Reset (async assert, sync-safe deassert):
  - count=0, so `valid_o`=0 and `ready_o`=1.
  - `binary_o`=0, `zero_o`=0, `err_o`=0, `err_cnt_o`=0.
  - Buffer contents are cleared.
- Reset mid-operation: all buffered entries are discarded and the counter zeroes immediately. The first accept is possible on the first edge after deassertion.
- Latency: a vector accepted at edge N appears on `valid_o`/`binary_o` after edge N (visible in cycle N+1) if the buffer was empty.
- Throughput: 1 per cycle while `ready_i`=1.
- With `ready_i`=0, two vectors are absorbed, then `ready_o` drops the cycle after the second accept.
- Outputs are stable while `valid_o && !ready_i`.
- `err_cnt_o` updates on the edge of acceptance and is visible the next cycle.

## Test plan
- Reset, then drive single-hot vectors 0x001, 0x002, 0x004, … 0x200 back-to-back in strict mode with `ready_i`=1:
  - `binary_o` = 1..10 on consecutive cycles, one cycle after each accept.
  - `err_o`=0 throughout.
- All-zero input, strict mode → `binary_o`=0, `zero_o`=1, `err_o`=0, `err_cnt_o` unchanged.
- Input 0x0A4 (bits 2, 5, 7):
  - mode 01 → index 3.
  - mode 10 → index 8.
  - mode 00 → index 0, `err_o`=1, `err_cnt_o` +1.
  - mode 11 → same as mode 00.
- Backpressure: hold `ready_i`=0 and offer 3 vectors (0x001, 0x002, 0x004):
  - first two are accepted, `ready_o`=0 on the third.
  - Release `ready_i`: outputs 1, 2, then 3 in order, with no loss or duplication.
- Counter saturation with `ERR_CNT_W_P`=2: send 5 multi-hot strict vectors → `err_cnt_o`=3.
  - Assert `clear_err_i` in the same cycle as a 6th error → `err_cnt_o`=0.
- Assert `rst_ni` low with 2 entries buffered and `err_cnt_o`=5 → `valid_o`=0, `ready_o`=1, `err_cnt_o`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/onehot_encoder_pipe_if.sv
// Handshaked bus for the one-hot encoder: input vector side and encoded-index side.
interface onehot_encoder_pipe_if #(
  parameter int WIDTH_P = 10,
  parameter int IDX_W_P = $clog2(WIDTH_P + 1)
);
  logic               valid_i;
  logic               ready_o;
  logic [WIDTH_P-1:0] one_hot_i;
  logic [1:0]         mode_i;
  logic               valid_o;
  logic               ready_i;
  logic [IDX_W_P-1:0] binary_o;
  logic               zero_o;
  logic               err_o;

  modport slave (
    input  valid_i, one_hot_i, mode_i, ready_i,
    output ready_o, valid_o, binary_o, zero_o, err_o
  );

  modport master (
    output valid_i, one_hot_i, mode_i, ready_i,
    input  ready_o, valid_o, binary_o, zero_o, err_o
  );
endinterface

// File: rtl/onehot_encoder_pipe.sv
// One-hot/multi-hot to binary index encoder with strict or priority decode,
// a 2-entry output FIFO and a saturating strict-mode error counter.
module onehot_encoder_pipe #(
  parameter int WIDTH_P     = 10,
  parameter int IDX_W_P     = $clog2(WIDTH_P + 1),
  parameter int ERR_CNT_W_P = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  onehot_encoder_pipe_if.slave   bus,
  input  logic                   clear_err_i,
  output logic [ERR_CNT_W_P-1:0] err_cnt_o
);

  typedef struct packed {
    logic [IDX_W_P-1:0] idx;
    logic               zero;
    logic               err;
  } entry_t;

  entry_t [1:0]           slot_q, slot_d;
  logic   [1:0]           count_q, count_d;
  logic [ERR_CNT_W_P-1:0] cnt_q, cnt_d;

  logic [IDX_W_P-1:0] lsb_idx, msb_idx;
  logic               multi, zero, strict;
  logic               push, pop, ready, valid;
  entry_t             enc;

  // Index is bit position + 1 so that 0 stays reserved for "no valid bit".
  always_comb begin
    lsb_idx = '0;
    msb_idx = '0;
    for (int i = WIDTH_P - 1; i >= 0; i--)
      if (bus.one_hot_i[i]) lsb_idx = IDX_W_P'(i + 1);
    for (int i = 0; i < WIDTH_P; i++)
      if (bus.one_hot_i[i]) msb_idx = IDX_W_P'(i + 1);
  end

  // v & (v-1) clears the lowest set bit; anything left means popcount >= 2.
  assign multi  = |(bus.one_hot_i & (bus.one_hot_i - WIDTH_P'(1)));
  assign zero   = ~|bus.one_hot_i;
  assign strict = (bus.mode_i[0] == bus.mode_i[1]);

  always_comb begin
    enc      = '0;
    enc.zero = zero;
    if (strict) begin
      enc.idx = multi ? '0 : lsb_idx;
      enc.err = multi;
    end else if (bus.mode_i == 2'b01) begin
      enc.idx = lsb_idx;
    end else begin
      enc.idx = msb_idx;
    end
  end

  assign ready = (count_q != 2'd2);
  assign valid = (count_q != 2'd0);
  assign push  = bus.valid_i && ready;
  assign pop   = valid && bus.ready_i;

  // Slot 0 is always the head; push+pop can only coincide at count 1.
  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    if (push && pop) begin
      slot_d[0] = enc;
    end else if (pop) begin
      slot_d[0] = slot_q[1];
      slot_d[1] = '0;
      count_d   = count_q - 2'd1;
    end else if (push) begin
      if (count_q == 2'd0) slot_d[0] = enc;
      else                 slot_d[1] = enc;
      count_d = count_q + 2'd1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_err_i)
      cnt_d = '0;
    else if (push && strict && multi && !(&cnt_q))
      cnt_d = cnt_q + ERR_CNT_W_P'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q  <= '0;
      count_q <= '0;
      cnt_q   <= '0;
    end else begin
      slot_q  <= slot_d;
      count_q <= count_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ready_o  = ready;
  assign bus.valid_o  = valid;
  assign bus.binary_o = valid ? slot_q[0].idx  : '0;
  assign bus.zero_o   = valid ? slot_q[0].zero : 1'b0;
  assign bus.err_o    = valid ? slot_q[0].err  : 1'b0;
  assign err_cnt_o    = cnt_q;

endmodule
